// File: rtl/adc_scan_uart_tx.sv
`default_nettype none
// ---- adc_scan_uart_tx : round-robin ADC0809-class scanner with 8N1 framed snapshot streaming ----
// ---- rev 1.0 ----
module adc_scan_uart_tx #(
  parameter int         NUM_CH      = 8,
  parameter int         ADC_CLK_DIV = 50,
  parameter int         BAUD_DIV    = 5208,
  parameter int         EOC_TIMEOUT = 1023,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  input  logic       eoc,
  input  logic [7:0] result,
  output logic       adc_clk,
  output logic       ale,
  output logic       start,
  output logic       out_en,
  output logic [2:0] addr,
  output logic [7:0] led,
  output logic       tx_out,
  output logic       busy,
  output logic       err
);

  localparam int DIV_W  = $clog2(ADC_CLK_DIV + 1);
  localparam int WAIT_W = $clog2(EOC_TIMEOUT + 1);
  localparam int BAUD_W = $clog2(BAUD_DIV + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ADC_CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EOC_TIMEOUT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [3:0]        LAST_BYTE = 4'(NUM_CH + 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    S_SET_ADDR = 3'd0,
    S_ALE      = 3'd1,
    S_START    = 3'd2,
    S_WAIT_LO  = 3'd3,
    S_WAIT_HI  = 3'd4,
    S_OE       = 3'd5,
    S_LATCH    = 3'd6
  } scan_state_t;

  // ADC conversion clock; a tick is the cycle in which adc_clk rises.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST) && !adc_clk;

  logic eoc_meta;
  logic eoc_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
    end else begin
      eoc_meta <= eoc;
      eoc_sync <= eoc_meta;
    end
  end

  scan_state_t       state;
  scan_state_t       state_nx;
  logic [2:0]        ch;
  logic [2:0]        ch_nx;
  logic [2:0]        addr_nx;
  logic              ale_nx;
  logic              start_nx;
  logic              oe_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              timeout;
  logic              sweep_done;
  logic [7:0]        samples [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_SET_ADDR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    ale_nx   = ale;
    start_nx = start;
    oe_nx    = out_en;
    wait_nx  = wait_cnt;
    wr_en    = 1'b0;
    wr_data  = result;
    timeout  = 1'b0;
    if (tick) begin
      case (state)
        S_SET_ADDR: begin
          addr_nx  = ch;
          state_nx = S_ALE;
        end
        S_ALE: begin
          ale_nx   = 1'b1;
          state_nx = S_START;
        end
        S_START: begin
          ale_nx   = 1'b1;
          start_nx = 1'b1;
          wait_nx  = '0;
          state_nx = S_WAIT_LO;
        end
        S_WAIT_LO, S_WAIT_HI: begin
          ale_nx   = 1'b0;
          start_nx = 1'b0;
          if (state == S_WAIT_LO && !eoc_sync) begin
            state_nx = S_WAIT_HI;
          end else if (state == S_WAIT_HI && eoc_sync) begin
            state_nx = S_OE;
          end else if (wait_cnt == WAIT_LAST) begin
            // Dead or missing converter: mark the channel and keep the scan moving.
            timeout  = 1'b1;
            wr_en    = 1'b1;
            wr_data  = 8'hFF;
            state_nx = S_SET_ADDR;
          end
          if (wait_cnt != WAIT_LAST) begin
            wait_nx = wait_cnt + 1'b1;
          end
        end
        S_OE: begin
          oe_nx    = 1'b1;
          state_nx = S_LATCH;
        end
        S_LATCH: begin
          oe_nx    = 1'b0;
          wr_en    = 1'b1;
          state_nx = S_SET_ADDR;
        end
        default: begin
          state_nx = S_SET_ADDR;
        end
      endcase
    end
    ch_nx = ch;
    if (wr_en) begin
      ch_nx = (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch         <= 3'd0;
      addr       <= 3'd0;
      ale        <= 1'b0;
      start      <= 1'b0;
      out_en     <= 1'b0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      led        <= 8'h00;
      sweep_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        samples[i] <= 8'h00;
      end
    end else begin
      ch         <= ch_nx;
      addr       <= addr_nx;
      ale        <= ale_nx;
      start      <= start_nx;
      out_en     <= oe_nx;
      wait_cnt   <= wait_nx;
      sweep_done <= wr_en && (ch == LAST_CH);
      if (timeout) begin
        err <= 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && ch == 3'(i)) begin
          samples[i] <= wr_data;
        end
      end
      if (wr_en && ch == 3'd0) begin
        led <= wr_data;
      end
    end
  end

  // Frame transmitter: HEADER, shadow[0..NUM_CH-1], checksum, sent back-to-back.
  logic              trigger;
  logic [7:0]        shadow [NUM_CH];
  logic [7:0]        chk;
  logic [7:0]        chk_sum;
  logic [7:0]        next_byte;
  logic [3:0]        byte_idx;
  logic [3:0]        bit_idx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [8:0]        tx_sh;

  assign trigger = sweep_done && sw && !busy;

  always_comb begin
    chk_sum = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      chk_sum = chk_sum + samples[i];
    end
  end

  // Byte that follows the one indexed by byte_idx.
  always_comb begin
    next_byte = chk;
    for (int i = 0; i < NUM_CH; i++) begin
      if (byte_idx == 4'(i)) begin
        next_byte = shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      chk      <= 8'h00;
      byte_idx <= 4'd0;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
      tx_sh    <= 9'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= 8'h00;
      end
    end else if (trigger) begin
      busy     <= 1'b1;
      tx_out   <= 1'b0;
      tx_sh    <= {1'b1, HEADER};
      byte_idx <= 4'd0;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
      chk      <= chk_sum;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= samples[i];
      end
    end else if (busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == STOP_BIT) begin
          if (byte_idx == LAST_BYTE) begin
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 4'd1;
            bit_idx  <= 4'd0;
            tx_out   <= 1'b0;
            tx_sh    <= {1'b1, next_byte};
          end
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx_out  <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
